// File: rtl/receiver.sv
`default_nettype none
// receiver: UART RX, 16x oversampled, 5-8 data bits, 1/2 stop bits, FWFT RX FIFO, 10 ms line-low config detect.
// Optional macro RX_SYNC_EN inserts a 2-flop synchronizer on rx_i. Rev 1.0
module receiver #(
  parameter int RX_FIFO_DEPTH     = 32,
  parameter int SYSTEM_CLOCK_FREQ = 100_000_000
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       ov_baud_rt_i,
  input  logic       rx_i,
  input  logic       rx_fifo_read_i,
  input  logic [1:0] data_width_i,
  input  logic [1:0] stop_bits_number_i,
  output logic [7:0] data_rx_o,
  output logic       rx_done_o,
  output logic       frame_error_o,
  output logic       overrun_error_o,
  output logic       config_req_slv_o,
  output logic       rx_fifo_empty_o,
  output logic       rx_fifo_full_o
);
  localparam int COUNT_10MS = SYSTEM_CLOCK_FREQ / 100;
  localparam int LOW_W      = $clog2(COUNT_10MS + 1);
  localparam int AW         = $clog2(RX_FIFO_DEPTH);
  localparam logic [LOW_W-1:0] LOW_MAX = LOW_W'(COUNT_10MS);
  localparam logic [1:0] SB_2BIT = 2'd1;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] START    = 3'd1;
  localparam logic [2:0] DATA     = 3'd2;
  localparam logic [2:0] STOP     = 3'd3;
  localparam logic [2:0] CFG_WAIT = 3'd4;

  logic rx;
`ifdef RX_SYNC_EN
  logic [1:0] rx_sync;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) rx_sync <= 2'b11;
    else          rx_sync <= {rx_sync[0], rx_i};
  end
  assign rx = rx_sync[1];
`else
  assign rx = rx_i;
`endif

  // Line-low timer; cfg_seen limits the request to one pulse per low period.
  logic [LOW_W-1:0] low_cnt;
  logic             cfg_seen;
  logic             low_max;
  assign low_max = (low_cnt == LOW_MAX);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      low_cnt  <= '0;
      cfg_seen <= 1'b0;
    end else if (rx) begin
      low_cnt  <= '0;
      cfg_seen <= 1'b0;
    end else begin
      if (!low_max) low_cnt <= low_cnt + 1'b1;
      if (low_max)  cfg_seen <= 1'b1;
    end
  end
  assign config_req_slv_o = low_max && !cfg_seen;

  logic [2:0] state, next_state;
  logic [3:0] tick_cnt;
  logic [2:0] bit_cnt;
  logic       stop_cnt;
  logic [1:0] dw;
  logic [7:0] shift;
  logic       mid_start, sample, last_bit, two_stop;
  logic       frame_ok, fifo_wr, fifo_rd;
  logic [AW:0] wr_ptr, rd_ptr;

  assign mid_start = ov_baud_rt_i && (tick_cnt == 4'd7);
  assign sample    = ov_baud_rt_i && (tick_cnt == 4'd15);
  assign last_bit  = (bit_cnt == (3'd4 + {1'b0, dw}));
  assign two_stop  = (stop_bits_number_i == SB_2BIT) && !stop_cnt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (!rx) next_state = START;
      START:    if (mid_start) next_state = rx ? IDLE : DATA;
      DATA:     if (sample && last_bit) next_state = STOP;
      STOP:     if (sample && (!rx || !two_stop)) next_state = IDLE;
      CFG_WAIT: if (rx) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
    if (state != CFG_WAIT && low_max) next_state = CFG_WAIT;
  end

  // A frame cut short by a config request ends silently.
  always_comb begin
    frame_ok      = 1'b0;
    frame_error_o = 1'b0;
    if (state == STOP && sample && !low_max) begin
      if (!rx)            frame_error_o = 1'b1;
      else if (!two_stop) frame_ok      = 1'b1;
    end
    fifo_wr         = frame_ok && !rx_fifo_full_o;
    rx_done_o       = fifo_wr;
    overrun_error_o = frame_ok && rx_fifo_full_o;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tick_cnt <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      dw       <= '0;
      shift    <= '0;
    end else begin
      case (state)
        START: if (ov_baud_rt_i) begin
          tick_cnt <= mid_start ? 4'd0 : tick_cnt + 4'd1;
          if (mid_start) begin
            shift <= '0;
            dw    <= data_width_i;
          end
        end
        DATA: if (ov_baud_rt_i) begin
          tick_cnt <= tick_cnt + 4'd1;
          if (tick_cnt == 4'd15) begin
            shift[bit_cnt] <= rx;
            bit_cnt        <= bit_cnt + 3'd1;
          end
        end
        STOP: if (ov_baud_rt_i) begin
          tick_cnt <= tick_cnt + 4'd1;
          if (tick_cnt == 4'd15) stop_cnt <= 1'b1;
        end
        default: begin
          tick_cnt <= '0;
          bit_cnt  <= '0;
          stop_cnt <= 1'b0;
        end
      endcase
    end
  end

  // FWFT FIFO: full is judged before any same-cycle pop.
  logic [7:0] mem [RX_FIFO_DEPTH];
  assign rx_fifo_empty_o = (wr_ptr == rd_ptr);
  assign rx_fifo_full_o  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign fifo_rd         = rx_fifo_read_i && !rx_fifo_empty_o;
  assign data_rx_o       = rx_fifo_empty_o ? 8'd0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (fifo_wr) mem[wr_ptr[AW-1:0]] <= shift;
  end
endmodule
`default_nettype wire

// File: tb/tb_receiver.sv
`default_nettype none
// tb_receiver: randomized UART frames checked against a queue model of the RX FIFO and pulse counters.
module tb_receiver;
  localparam int DEPTH = 32;
  localparam int FREQ  = 100_000;
  localparam int COUNT = FREQ / 100;
  localparam int DIV   = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       rx = 1'b1;
  logic       rd = 1'b0;
  logic [1:0] dw = 2'd3;
  logic [1:0] sb = 2'd0;
  logic [7:0] data_rx;
  logic       rx_done, frame_error, overrun_error, config_req, fifo_empty, fifo_full;

  receiver #(.RX_FIFO_DEPTH(DEPTH), .SYSTEM_CLOCK_FREQ(FREQ)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .ov_baud_rt_i(tick), .rx_i(rx), .rx_fifo_read_i(rd),
    .data_width_i(dw), .stop_bits_number_i(sb), .data_rx_o(data_rx), .rx_done_o(rx_done),
    .frame_error_o(frame_error), .overrun_error_o(overrun_error), .config_req_slv_o(config_req),
    .rx_fifo_empty_o(fifo_empty), .rx_fifo_full_o(fifo_full)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int done_n = 0, ferr_n = 0, ovr_n = 0, cfg_n = 0, excl_viol = 0, cfg_mism = 0;
  int low_run = 0;
  bit cfg_prev = 1'b0;
  bit tick_en = 1'b1;
  logic [7:0] exp_q[$];

  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk); #1;
      tick = tick_en && (ph == 0);
      ph = (ph + 1) % DIV;
    end
  end

  // Reference for the line-low timer: consecutive low clocks, saturating.
  always @(posedge clk) begin
    if (!rst_n || rx) low_run = 0;
    else if (low_run < COUNT) low_run++;
  end

  always @(negedge clk) begin
    bit exp_cfg;
    if (rx_done) done_n++;
    if (frame_error) ferr_n++;
    if (overrun_error) ovr_n++;
    if (config_req) cfg_n++;
    if (int'(rx_done) + int'(frame_error) + int'(overrun_error) > 1) excl_viol++;
    exp_cfg  = (low_run == COUNT) && !cfg_prev;
    cfg_prev = (low_run == COUNT);
    if (config_req !== exp_cfg) cfg_mism++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    int k;
    k = 0;
    while (k < n) begin
      @(posedge clk);
      if (tick) k++;
    end
    #1;
  endtask

  // Bad stop is held low for only 10 ticks so the trailing edge cannot look like a start bit.
  task automatic send_frame(input logic [7:0] d, input int nbits, input int nstop, input bit bad_stop);
    rx = 1'b0; wait_ticks(16);
    for (int i = 0; i < nbits; i++) begin
      rx = d[i]; wait_ticks(16);
    end
    if (bad_stop) begin
      rx = 1'b0; wait_ticks(10);
      rx = 1'b1; wait_ticks(20);
    end else begin
      rx = 1'b1; wait_ticks(16 * nstop);
    end
  endtask

  task automatic check_fifo(input string tag);
    check({tag, " head"}, data_rx, (exp_q.size() > 0) ? exp_q[0] : 8'h00);
    check({tag, " empty"}, fifo_empty, exp_q.size() == 0);
    check({tag, " full"}, fifo_full, exp_q.size() == DEPTH);
  endtask

  task automatic good_frame(input logic [7:0] d, input logic [1:0] w, input logic [1:0] s, input string tag);
    int d0, o0, f0, nb, mask;
    bit room;
    nb = 5 + int'(w);
    mask = (1 << nb) - 1;
    dw = w; sb = s;
    d0 = done_n; o0 = ovr_n; f0 = ferr_n;
    room = exp_q.size() < DEPTH;
    send_frame(d, nb, (s == 2'd1) ? 2 : 1, 1'b0);
    if (room) exp_q.push_back(d & mask[7:0]);
    check({tag, " done"}, done_n - d0, room ? 1 : 0);
    check({tag, " overrun"}, ovr_n - o0, room ? 0 : 1);
    check({tag, " ferr"}, ferr_n - f0, 0);
    check_fifo(tag);
  endtask

  task automatic pop_check(input string tag);
    check({tag, " pop head"}, data_rx, (exp_q.size() > 0) ? exp_q[0] : 8'h00);
    rd = 1'b1; @(posedge clk); #1; rd = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  initial begin
    int d0, f0, o0, c0;
    repeat (4) @(posedge clk);
    check("reset empty", fifo_empty, 1);
    check("reset full", fifo_full, 0);
    check("reset data", data_rx, 8'h00);
    check("reset pulses", {rx_done, frame_error, overrun_error, config_req}, 4'b0000);
    @(posedge clk); #1; rst_n = 1'b1;
    wait_ticks(20);

    good_frame(8'hA5, 2'd3, 2'd0, "8N1 A5");
    pop_check("8N1 A5");
    check("8N1 A5 cleared", fifo_empty, 1);

    dw = 2'd0; sb = 2'd1; d0 = done_n;
    send_frame(8'h1B, 5, 1, 1'b0);
    check("5N2 no done after stop1", done_n - d0, 0);
    wait_ticks(16);
    check("5N2 done after stop2", done_n - d0, 1);
    exp_q.push_back(8'h1B);
    check_fifo("5N2 1B");
    pop_check("5N2 1B");

    dw = 2'd3; sb = 2'd0; d0 = done_n; f0 = ferr_n;
    send_frame(8'h3C, 8, 1, 1'b1);
    check("bad stop ferr", ferr_n - f0, 1);
    check("bad stop done", done_n - d0, 0);
    check_fifo("bad stop");
    good_frame(8'h55, 2'd3, 2'd0, "after ferr 55");
    pop_check("after ferr 55");

    d0 = done_n; f0 = ferr_n; o0 = ovr_n;
    rx = 1'b0; wait_ticks(4);
    rx = 1'b1; wait_ticks(24);
    check("glitch pulses", (done_n - d0) + (ferr_n - f0) + (ovr_n - o0), 0);
    check_fifo("glitch");
    good_frame(8'($urandom), 2'($urandom), 2'($urandom), "after glitch");
    pop_check("after glitch");

    for (int i = 0; i < 10; i++) begin
      good_frame(8'($urandom), 2'($urandom), 2'($urandom), "random");
      if ($urandom_range(1, 0) == 1) pop_check("random");
    end
    while (exp_q.size() > 0) pop_check("random drain");
    check_fifo("random drained");

    rx = 1'b0; wait_ticks(40);
    rx = 1'b1; rst_n = 1'b0;
    repeat (3) @(posedge clk); #1;
    check_fifo("reset mid-frame");
    rst_n = 1'b1; wait_ticks(20);
    good_frame(8'h3E, 2'd3, 2'd0, "after reset");
    pop_check("after reset");

    for (int i = 0; i < DEPTH; i++) good_frame(8'($urandom), 2'd3, 2'd0, "fill");
    good_frame(8'h77, 2'd3, 2'd0, "overrun 77");
    while (exp_q.size() > 0) pop_check("fill drain");
    check_fifo("fill drained");

    d0 = done_n; f0 = ferr_n; c0 = cfg_n;
    rx = 1'b0; wait_ticks(48);
    tick_en = 1'b0;
    for (int c = 0; c < COUNT + 100 && cfg_n == c0; c++) @(posedge clk);
    #1;
    check("cfg pulse seen", cfg_n - c0, 1);
    repeat (30) @(posedge clk); #1;
    check("cfg single pulse", cfg_n - c0, 1);
    check("cfg no ferr", ferr_n - f0, 0);
    check("cfg no done", done_n - d0, 0);
    rx = 1'b1; tick_en = 1'b1;
    wait_ticks(20);
    good_frame(8'h81, 2'd3, 2'd0, "after cfg 81");
    pop_check("after cfg 81");

    check("pulse exclusivity", excl_viol, 0);
    check("cfg pulse timing", cfg_mism, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog tests=%0d", tests);
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire

// File: doc/receiver.md
Name: receiver

Overview:
- UART serial receiver: the receive half of the link whose transmit half drives the TX line.
- Oversamples rx_i at 16x the baud rate using the shared ov_baud_rt_i tick. Recovers frames of 5-8 data bits, LSB first, with 1 or 2 stop bits, and pushes good bytes into an RX FIFO in FWFT mode.
- Detects a configuration request: the remote end holds the line low for 10 ms.
- Sits beside the transmitter inside the UART controller; data width and stop bit count come from the same configuration register.

Parameters:
- RX_FIFO_DEPTH, 32: RX FIFO depth in words (power of 2).
- SYSTEM_CLOCK_FREQ, 100_000_000: clock frequency in Hz; COUNT_10MS = SYSTEM_CLOCK_FREQ/100 (localparam).

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  reset, asynchronous assert, active-low
- ov_baud_rt_i  in  1  16x baud oversample tick, one clk wide
- rx_i  in  1  serial RX line, idle high
- rx_fifo_read_i  in  1  pop RX FIFO; data_rx_o is valid before the pop (FWFT)
- data_width_i  in  2  DW_5BIT/DW_6BIT/DW_7BIT/DW_8BIT
- stop_bits_number_i  in  2  SB_1BIT/SB_2BIT; other codes behave as 1 stop bit
- data_rx_o  out  8  FIFO head word, right-justified, unused MSBs zero
- rx_done_o  out  1  pulse: frame accepted into FIFO
- frame_error_o  out  1  pulse: a stop bit was sampled low
- overrun_error_o  out  1  pulse: good frame dropped because FIFO full
- config_req_slv_o  out  1  pulse: line low for COUNT_10MS clocks
- rx_fifo_empty_o  out  1  FIFO empty
- rx_fifo_full_o  out  1  FIFO full

Behaviour:
- Reset (async, rst_n_i=0):
  - FSM goes to IDLE; all counters are zero.
  - All pulse outputs are 0.
  - FIFO is empty: rx_fifo_empty_o=1, rx_fifo_full_o=0, data_rx_o=0.
  - Reset mid-frame discards the partial frame.
- Counters:
  - tick counter: 4 bits, counts ov_baud_rt_i ticks.
  - bit counter: 3 bits.
  - stop counter: 1 bit.
  - low counter: $clog2(COUNT_10MS+1) bits.
- FSM states: IDLE, START, DATA, STOP, CFG_WAIT.
  - IDLE: rx_i=0 -> START with tick counter cleared.
  - START: on tick 7, if rx_i=1, it is a false start -> IDLE. Otherwise clear the tick counter and -> DATA.
  - DATA: every 16 ticks (counter==15), sample rx_i into bit[bit counter] and increment the bit counter.
    - After the sample of bit 4/5/6/7 (per data_width_i) -> STOP.
    - data_width_i is sampled at the START->DATA transition and held for the frame.
  - STOP: sample at counter==15.
    - Sample low -> frame_error_o pulse, frame discarded -> IDLE.
    - SB_2BIT with the first stop bit good -> stay in STOP for a second sample.
    - Final stop bit good -> write the word to the FIFO, pulse rx_done_o the same cycle -> IDLE.
  - CFG_WAIT: entered from any state when the low counter reaches COUNT_10MS.
    - Any partial frame is discarded; no frame_error_o is raised for it.
    - Stays in CFG_WAIT until rx_i=1, then -> IDLE.
- Config detect:
  - The low counter increments every clk while rx_i=0 and clears when rx_i=1.
  - It saturates at COUNT_10MS.
  - config_req_slv_o pulses exactly once, in the cycle the counter first equals COUNT_10MS.
- FIFO full on a good frame:
  - The word is dropped and overrun_error_o pulses instead of rx_done_o.
  - FIFO contents are unchanged.
- Simultaneous FIFO write and rx_fifo_read_i: both are performed.
  - Empty FIFO: the new word appears at the head next cycle.
  - Full FIFO: the write is blocked (overrun) because full is evaluated before the pop.
- Latency: rx_done_o fires in the clk of the 16th tick of the final stop bit; the data is visible on data_rx_o the following cycle when the FIFO was empty.
- Pulse outputs are mutually exclusive except config_req_slv_o.

Optional Feature:
- Macro RX_SYNC_EN.
- Defined: rx_i passes through a 2-flop synchronizer, reset to 1, before all logic. All detection is delayed 2 clk.
- Undefined: rx_i is used directly; the source must already be synchronous to clk_i.

Test Plan:
- 8N1, byte 0xA5 sent at 16x ticks -> rx_done_o pulses once; data_rx_o=0xA5 after the pulse; rx_fifo_empty_o falls; read clears it.
- 5-bit, 2 stop bits, byte 0x1B -> data_rx_o=0x1B, upper bits zero; rx_done_o only after the second stop bit.
- Stop bit driven low on 0x3C -> frame_error_o pulse; FIFO remains empty; next good frame 0x55 is received.
- Glitch: rx_i low for 4 ticks then high -> back to IDLE; no outputs; next frame received correctly.
- FIFO filled with RX_FIFO_DEPTH frames, no reads, one more frame 0x77 -> overrun_error_o pulse; FIFO head still the first byte.
- rx_i held low for COUNT_10MS clk, mid-frame -> config_req_slv_o single pulse; no frame_error_o; after release high, 0x81 is received.
